// File: rtl/ram_bist_ctrl_pkg.sv
// Shared definitions for the RAM BIST controller: defaults, FSM states and the
// LFSR polynomial used to generate the write/read data pattern.
package ram_pkg;

   localparam int          DW_DEF    = 16;
   localparam int          AW_DEF    = 8;
   localparam logic [15:0] SEED_DEF  = 16'hACE1;
   // Taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting register
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      GAP,
      READ,
      DRAIN,
      DONE
   } state_e;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// Control/status and RAM port bundle between the BIST controller (master)
// and the RAM plus its requester (slave).
interface ram_bist_ctrl_if
   import ram_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
);

   logic          start;
   logic          ram_wr;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          busy;
   logic          done;
   logic          pass;
   logic [7:0]    err_cnt;
   logic [AW-1:0] first_err_addr;

   modport master (
      input  start, ram_dout,
      output ram_wr, ram_addr, ram_din, busy, done, pass, err_cnt, first_err_addr
   );

   modport slave (
      output start, ram_dout,
      input  ram_wr, ram_addr, ram_din, busy, done, pass, err_cnt, first_err_addr
   );

endinterface

// File: rtl/ram_bist_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and step enable; reset loads
// the seed so the pattern restarts cleanly after an abort.
module lfsr16
   import ram_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        en,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = seed;
      end else if (en) begin
         q_d = lfsr_step(q_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q_q <= seed;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-style RAM BIST: write an LFSR pattern to DEPTH words, read it back,
// and report mismatch count, first failing address and pass/fail.
module ram_bist_ctrl
   import ram_pkg::*;
#(
   parameter int          DW    = DW_DEF,
   parameter int          AW    = AW_DEF,
   parameter int          DEPTH = 10,
   parameter logic [15:0] SEED  = SEED_DEF
)(
   input  logic            clk,
   input  logic            rst,
   ram_bist_ctrl_if.master bus
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] exp_addr_q, exp_addr_d;
   logic [AW-1:0] first_q, first_d;
   logic [DW-1:0] din_q, din_d;
   logic [DW-1:0] exp_q, exp_d;
   logic          cmp_q, cmp_d;
   logic          pass_q, pass_d;
   logic [7:0]    err_q, err_d;

   logic          lfsr_load, lfsr_en;
   logic [15:0]   lfsr_q;
   logic [DW-1:0] lfsr_word;

   lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load),
      .en   (lfsr_en),
      .seed (SEED),
      .q    (lfsr_q)
   );

   assign lfsr_word = DW'(lfsr_q);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      exp_addr_d = exp_addr_q;
      first_d    = first_q;
      din_d      = din_q;
      exp_d      = exp_q;
      cmp_d      = 1'b0;
      pass_d     = pass_q;
      err_d      = err_q;
      lfsr_load  = 1'b0;
      lfsr_en    = 1'b0;

      // Read data lags the address by one cycle, so the check uses the
      // expectation registered during the previous READ cycle.
      if (cmp_q && (bus.ram_dout != exp_q)) begin
         if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
         end
         if (first_q == '1) begin
            first_d = exp_addr_q;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = WRITE;
               err_d     = '0;
               pass_d    = 1'b0;
               first_d   = '1;
               idx_d     = '0;
               lfsr_load = 1'b1;
            end
         end
         WRITE: begin
            din_d   = lfsr_word;
            lfsr_en = 1'b1;
            idx_d   = idx_q + AW'(1);
            if (idx_q == LAST_IDX) begin
               state_d = GAP;
            end
         end
         GAP: begin
            lfsr_load = 1'b1;
            idx_d     = '0;
            state_d   = READ;
         end
         READ: begin
            exp_d      = lfsr_word;
            exp_addr_d = idx_q;
            cmp_d      = 1'b1;
            lfsr_en    = 1'b1;
            idx_d      = idx_q + AW'(1);
            if (idx_q == LAST_IDX) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            pass_d  = (err_d == 8'd0);
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         exp_addr_q <= '0;
         first_q    <= '1;
         din_q      <= '0;
         exp_q      <= '0;
         cmp_q      <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         exp_addr_q <= exp_addr_d;
         first_q    <= first_d;
         din_q      <= din_d;
         exp_q      <= exp_d;
         cmp_q      <= cmp_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
      end
   end

   assign bus.ram_wr         = (state_q == WRITE);
   assign bus.ram_addr       = idx_q;
   assign bus.ram_din        = (state_q == WRITE) ? lfsr_word : din_q;
   assign bus.busy           = (state_q == WRITE) || (state_q == GAP) ||
                               (state_q == READ)  || (state_q == DRAIN);
   assign bus.done           = (state_q == DONE);
   assign bus.pass           = pass_q;
   assign bus.err_cnt        = err_q;
   assign bus.first_err_addr = first_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Randomized self-checking bench for ram_bist_ctrl with a behavioural RAM and
// a pattern/result model derived from the LFSR polynomial and run timing.
module tb_ram_bist_ctrl;

   localparam int          DW   = 16;
   localparam int          AW   = 8;
   localparam int          D10  = 10;
   localparam int          D255 = 255;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   ram_bist_ctrl_if #(.DW(DW), .AW(AW)) bus_a ();
   ram_bist_ctrl_if #(.DW(DW), .AW(AW)) bus_b ();

   ram_bist_ctrl #(.DW(DW), .AW(AW), .DEPTH(D10), .SEED(SEED)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.master)
   );

   ram_bist_ctrl #(.DW(DW), .AW(AW), .DEPTH(D255), .SEED(SEED)) dut255 (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.master)
   );

   // Behavioural RAM for the DEPTH=10 instance with per-address read faults
   logic [DW-1:0] mem  [0:255];
   logic [DW-1:0] flip [0:255];
   bit            zero_mode = 1'b0;
   logic [AW-1:0] wlog_a[$];
   logic [DW-1:0] wlog_d[$];

   always @(posedge clk) begin
      if (bus_a.ram_wr === 1'b1) begin
         mem[bus_a.ram_addr] <= bus_a.ram_din;
         wlog_a.push_back(bus_a.ram_addr);
         wlog_d.push_back(bus_a.ram_din);
      end
      bus_a.ram_dout <= zero_mode ? '0 : (mem[bus_a.ram_addr] ^ flip[bus_a.ram_addr]);
   end

   // The long instance sees a RAM that always reads back zero
   always @(posedge clk) bus_b.ram_dout <= '0;

   logic [15:0] ref_words [0:D255-1];

   function automatic logic [15:0] next_word(input logic [15:0] v);
      logic fb;
      fb = v[15] ^ v[13] ^ v[12] ^ v[10];
      return {v[14:0], fb};
   endfunction

   task automatic build_model();
      logic [15:0] w;
      w = SEED;
      for (int i = 0; i < D255; i++) begin
         ref_words[i] = w;
         w = next_word(w);
      end
      for (int i = 0; i < 256; i++) begin
         mem[i]  = DW'($urandom);
         flip[i] = '0;
      end
   endtask

   task automatic model_result(output int e, output int first, output bit ok);
      logic [DW-1:0] rd;
      e = 0;
      first = 255;
      for (int i = 0; i < D10; i++) begin
         rd = zero_mode ? '0 : (ref_words[i] ^ flip[i]);
         if (rd != ref_words[i]) begin
            if (first == 255) first = i;
            e = (e < 255) ? e + 1 : 255;
         end
      end
      ok = (e == 0);
   endtask

   // Caller is at posedge+1 with the DUT in IDLE
   task automatic do_run(input int tag);
      int n, e, first;
      bit ok;
      wlog_a.delete();
      wlog_d.delete();
      bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      total++;
      if (bus_a.busy !== 1'b1 || bus_a.ram_wr !== 1'b1 || bus_a.ram_din !== ref_words[0]) begin
         bad++;
         $display("FAIL run%0d_first_write: busy=%b wr=%b din=%h, required 1 1 %h",
                  tag, bus_a.busy, bus_a.ram_wr, bus_a.ram_din, ref_words[0]);
      end
      n = 0;
      while (bus_a.done !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n !== 2 * D10 + 2) begin
         bad++;
         $display("FAIL run%0d_done_edge: got %0d, required %0d", tag, n, 2 * D10 + 2);
      end
      model_result(e, first, ok);
      total++;
      if (bus_a.pass !== ok || bus_a.err_cnt !== 8'(e) ||
          bus_a.first_err_addr !== AW'(first) || bus_a.busy !== 1'b0) begin
         bad++;
         $display("FAIL run%0d_result: pass=%b err=%0d first=%0d busy=%b, required %b %0d %0d 0",
                  tag, bus_a.pass, bus_a.err_cnt, bus_a.first_err_addr, bus_a.busy, ok, e, first);
      end
      total++;
      if (wlog_a.size() != D10) begin
         bad++;
         $display("FAIL run%0d_write_count: got %0d, required %0d", tag, wlog_a.size(), D10);
      end else begin
         for (int i = 0; i < D10; i++) begin
            total++;
            if (wlog_a[i] !== AW'(i) || wlog_d[i] !== ref_words[i]) begin
               bad++;
               $display("FAIL run%0d_write%0d: addr=%0d data=%h, required %0d %h",
                        tag, i, wlog_a[i], wlog_d[i], i, ref_words[i]);
            end
         end
      end
      @(posedge clk); #1;
      total++;
      if (bus_a.done !== 1'b0 || bus_a.pass !== ok) begin
         bad++;
         $display("FAIL run%0d_after_done: done=%b pass=%b, required 0 %b", tag, bus_a.done, bus_a.pass, ok);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus_a.ram_wr !== 1'b0 || bus_a.ram_addr !== '0 || bus_a.ram_din !== '0 ||
          bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.pass !== 1'b0 ||
          bus_a.err_cnt !== 8'd0 || bus_a.first_err_addr !== 8'hFF) begin
         bad++;
         $display("FAIL reset_state: wr=%b addr=%h din=%h busy=%b done=%b pass=%b err=%h first=%h, required 0 00 0000 0 0 0 00 ff",
                  bus_a.ram_wr, bus_a.ram_addr, bus_a.ram_din, bus_a.busy, bus_a.done,
                  bus_a.pass, bus_a.err_cnt, bus_a.first_err_addr);
      end
      rst = 1'b1;
   endtask

   task automatic test_good_ram();
      zero_mode = 1'b0;
      for (int i = 0; i < 256; i++) flip[i] = '0;
      do_run(1);
   endtask

   task automatic test_stuck_bit();
      flip[3] = 16'h0001;
      do_run(2);
      total++;
      if (bus_a.err_cnt !== 8'd1 || bus_a.first_err_addr !== 8'd3 || bus_a.pass !== 1'b0) begin
         bad++;
         $display("FAIL stuck_bit_addr3: err=%0d first=%0d pass=%b, required 1 3 0",
                  bus_a.err_cnt, bus_a.first_err_addr, bus_a.pass);
      end
      flip[3] = '0;
   endtask

   task automatic test_zero_ram();
      zero_mode = 1'b1;
      do_run(3);
      total++;
      if (bus_a.err_cnt !== 8'd10 || bus_a.first_err_addr !== 8'd0) begin
         bad++;
         $display("FAIL zero_ram: err=%0d first=%0d, required 10 0", bus_a.err_cnt, bus_a.first_err_addr);
      end
      zero_mode = 1'b0;
   endtask

   task automatic test_random_faults();
      for (int it = 0; it < 5; it++) begin
         for (int i = 0; i < D10; i++) begin
            flip[i] = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(1, 16'hFFFF)) : '0;
         end
         do_run(10 + it);
      end
      for (int i = 0; i < 256; i++) flip[i] = '0;
   endtask

   task automatic test_start_held();
      int dn[$];
      bus_a.start = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (i == 29) bus_a.start = 1'b0;
         if (bus_a.done === 1'b1) dn.push_back(i);
      end
      total++;
      if (dn.size() != 2) begin
         bad++;
         $display("FAIL start_held_runs: got %0d done pulses, required 2", dn.size());
      end else begin
         total++;
         if (dn[0] != 22 || dn[1] != 46 || bus_a.pass !== 1'b1) begin
            bad++;
            $display("FAIL start_held_timing: done at %0d,%0d pass=%b, required 22,46 1",
                     dn[0], dn[1], bus_a.pass);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int n, pulses;
      bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      n = 0;
      pulses = 0;
      while (bus_a.done !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
         bus_a.start = (n == 5 || n == 15) ? 1'b1 : 1'b0;
      end
      total++;
      if (n != 22) begin
         bad++;
         $display("FAIL busy_start_done_edge: got %0d, required 22", n);
      end
      bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      total++;
      if (bus_a.busy !== 1'b0 || bus_a.ram_wr !== 1'b0) begin
         bad++;
         $display("FAIL start_in_done_ignored: busy=%b wr=%b, required 0 0", bus_a.busy, bus_a.ram_wr);
      end
      repeat (30) begin
         @(posedge clk); #1;
         if (bus_a.done === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL busy_start_extra_done: got %0d pulses, required 0", pulses);
      end
   endtask

   task automatic test_reset_mid_run();
      int pulses;
      bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
      end
      total++;
      if (bus_a.ram_addr !== 8'd4 || bus_a.ram_wr !== 1'b0 || bus_a.busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_run_read4: addr=%0d wr=%b busy=%b, required 4 0 1",
                  bus_a.ram_addr, bus_a.ram_wr, bus_a.busy);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      total++;
      if (bus_a.ram_wr !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 ||
          bus_a.first_err_addr !== 8'hFF) begin
         bad++;
         $display("FAIL mid_run_abort: wr=%b busy=%b done=%b first=%h, required 0 0 0 ff",
                  bus_a.ram_wr, bus_a.busy, bus_a.done, bus_a.first_err_addr);
      end
      pulses = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus_a.done === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL mid_run_no_done: got %0d pulses, required 0", pulses);
      end
      do_run(20);
   endtask

   task automatic test_saturate();
      int n;
      bus_b.start = 1'b1;
      @(posedge clk); #1;
      bus_b.start = 1'b0;
      n = 0;
      while (bus_b.done !== 1'b1 && n < 700) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n != 2 * D255 + 2) begin
         bad++;
         $display("FAIL sat_done_edge: got %0d, required %0d", n, 2 * D255 + 2);
      end
      total++;
      if (bus_b.err_cnt !== 8'd255 || bus_b.first_err_addr !== 8'd0 || bus_b.pass !== 1'b0) begin
         bad++;
         $display("FAIL sat_result: err=%0d first=%0d pass=%b, required 255 0 0",
                  bus_b.err_cnt, bus_b.first_err_addr, bus_b.pass);
      end
   endtask

   initial begin
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      build_model();
      test_reset();
      test_good_ram();
      test_stuck_bit();
      test_zero_ram();
      test_random_faults();
      test_start_held();
      test_start_while_busy();
      test_reset_mid_run();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
